// File: rtl/axis_spi_slave.sv
// axis_spi_slave: SPI responder with full-duplex, MSB-first frames in SPI modes 0-3.
// SCLK, CS_N and MOSI are oversampled in the clk_i domain. There is no SPI-clock domain.
// TX bytes for MISO arrive on s_axis. RX bytes from MOSI leave on m_axis.
// Ports:
//   clk_i, rst_i                    system clock, synchronous active-high reset
//   cpol_i, cpha_i                  SPI mode, latched when a frame starts
//   spi_clk_i/cs_i/mosi_i           asynchronous pins from the master
//   spi_miso_o, spi_miso_oe_o       MISO data and its output enable
//   s_axis_*                        TX byte in, one-entry holding register
//   m_axis_*                        RX byte out
//   rx_overrun_o, tx_underrun_o     single-cycle error pulses
module axis_spi_slave #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_h, cs_h, mosi_h;
  logic                   sclk_s, cs_s;

  logic                   cpol_q, cpha_q, first_q;
  logic [CNT_W-1:0]       tx_cnt, rx_cnt;
  logic [DATA_WIDTH-2:0]  tx_rest;
  logic [DATA_WIDTH-1:0]  rx_shift, hold_data;
  logic                   tx_empty, miso_q, oe_q, rx_done_q;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic                   m_valid_q, overrun_q, underrun_q;

  logic start, abort;
  logic act, sclk_chg, lead, trail, shift_edge, sample_edge;
  logic tx_step, rx_step, boundary, tx_load, tx_shift_en, rx_last;
  logic [DATA_WIDTH-1:0] tx_pick;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Edge classification relative to the latched idle level of SCLK
  assign sclk_chg    = sclk_s ^ sclk_h;
  assign lead        = sclk_chg & (sclk_h == cpol_q);
  assign trail       = sclk_chg & (sclk_s == cpol_q);
  assign shift_edge  = cpha_q ? lead  : trail;
  assign sample_edge = cpha_q ? trail : lead;

  assign act     = (state_q == ST_ACTIVE) & ~cs_s;
  assign tx_step = act & shift_edge;
  assign rx_step = act & sample_edge;
  assign rx_last = rx_step & (rx_cnt == LAST_BIT);

  // CPHA=1 loads on the first leading edge of every byte but the first; the first byte was loaded at the CS fall
  assign boundary    = cpha_q ? ((tx_cnt == '0) & ~first_q) : (tx_cnt == LAST_BIT);
  assign tx_load     = start | (tx_step & boundary);
  assign tx_shift_en = tx_step & ~boundary & ~(cpha_q & (tx_cnt == '0));

  // Holding register, then a same-cycle bypass from s_axis, then the fill byte
  assign tx_pick = ~tx_empty      ? hold_data    :
                   s_axis_tvalid  ? s_axis_tdata : FILL_BYTE;

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign s_axis_tready = tx_empty;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign rx_overrun_o  = overrun_q;
  assign tx_underrun_o = underrun_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_RESYNC: if (cs_s) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cs_h & ~cs_s) begin
          state_d = ST_ACTIVE;
          start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  // Pin synchronisers and history flops; cs resets low so RESYNC waits for a real deassertion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_h    <= 1'b0;
      cs_h      <= 1'b0;
      mosi_h    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_h    <= sclk_s;
      cs_h      <= cs_s;
      mosi_h    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // State register, shifters, counters, TX holding register and RX output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RESYNC;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      first_q    <= 1'b0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tx_rest    <= '0;
      rx_shift   <= '0;
      hold_data  <= '0;
      tx_empty   <= 1'b1;
      miso_q     <= FILL_BYTE[DATA_WIDTH-1];
      oe_q       <= 1'b0;
      rx_done_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      oe_q       <= (state_d == ST_ACTIVE);
      underrun_q <= tx_load & tx_empty & ~s_axis_tvalid;
      overrun_q  <= 1'b0;
      rx_done_q  <= rx_last;

      if (start) begin
        cpol_q  <= cpol_i;
        cpha_q  <= cpha_i;
        first_q <= 1'b1;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
      end else if (abort) begin
        tx_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_step) begin
          tx_cnt  <= (tx_cnt == LAST_BIT) ? '0 : tx_cnt + CNT_W'(1);
          first_q <= 1'b0;
        end
        if (rx_step) begin
          rx_cnt   <= (rx_cnt == LAST_BIT) ? '0 : rx_cnt + CNT_W'(1);
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_h};
        end
      end

      // A load always empties the holding register; a concurrent handshake bypasses it
      if (tx_load) begin
        miso_q   <= tx_pick[DATA_WIDTH-1];
        tx_rest  <= tx_pick[DATA_WIDTH-2:0];
        tx_empty <= 1'b1;
      end else begin
        if (tx_shift_en) begin
          miso_q  <= tx_rest[DATA_WIDTH-2];
          tx_rest <= {tx_rest[DATA_WIDTH-3:0], 1'b0};
        end
        if (s_axis_tvalid & tx_empty) begin
          hold_data <= s_axis_tdata;
          tx_empty  <= 1'b0;
        end
      end

      // A completed byte is dropped only if the previous one is still stalled
      if (rx_done_q) begin
        if (m_valid_q & ~m_axis_tready) begin
          overrun_q <= 1'b1;
        end else begin
          m_data_q  <= rx_shift;
          m_valid_q <= 1'b1;
        end
      end else if (m_valid_q & m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_spi_slave.sv
// Testbench for axis_spi_slave: a behavioural SPI master with directed frames.
// Expected RX beats are queued when sent and popped by a monitor on each m_axis handshake.
module tb_axis_spi_slave;

  localparam int HALF = 8;  // clk cycles per SCLK half-period

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, sclk, cs, mosi;
  logic       miso, miso_oe;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready;
  logic       overrun, underrun;

  int n_vec   = 0;
  int n_fail  = 0;
  int n_under = 0;
  int n_over  = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] frame_q[$];

  always #5 clk = ~clk;

  axis_spi_slave dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpol_i        (cpol),
    .cpha_i        (cpha),
    .spi_clk_i     (sclk),
    .spi_cs_i      (cs),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .rx_overrun_o  (overrun),
    .tx_underrun_o (underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, want none", name);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the RX scoreboard on every handshake and counts error pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        if (rx_exp.size() == 0) fail_now("rx_unexpected_beat");
        else check("rx_beat", 32'(m_tdata), 32'(rx_exp.pop_front()));
      end
      if (underrun) n_under++;
      if (overrun)  n_over++;
    end
  end

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    wait_clk(4 * HALF);
  endtask

  // Shift nbits of tx out on MOSI, MSB first, collecting MISO at the master's sample edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) mosi = tx[7-i];
      wait_clk(HALF);
      sclk = ~cpol;
      if (!cpha) rd = {rd[6:0], miso};
      else       mosi = tx[7-i];
      wait_clk(HALF);
      sclk = cpol;
      if (cpha) rd = {rd[6:0], miso};
    end
  endtask

  // One CS frame carrying every byte in frame_q
  task automatic spi_frame(input bit chk_miso);
    logic [7:0] rd;
    cs = 1'b0;
    wait_clk(HALF);
    check("miso_oe_active", 32'(miso_oe), 32'd1);
    foreach (frame_q[k]) begin
      spi_bits(frame_q[k], 8, rd);
      if (chk_miso) begin
        if (miso_exp.size() == 0) fail_now("miso_no_expectation");
        else check("miso_byte", 32'(rd), 32'(miso_exp.pop_front()));
      end
    end
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(4 * HALF);
    check("miso_oe_idle", 32'(miso_oe), 32'd0);
  endtask

  task automatic tx_push(input logic [7:0] b);
    int t = 0;
    while (!s_tready && t < 5000) begin
      wait_clk(1);
      t++;
    end
    if (!s_tready) fail_now("tx_push_timeout");
    else begin
      s_tdata  = b;
      s_tvalid = 1'b1;
      wait_clk(1);
      s_tvalid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (rx_exp.size() != 0 && t < 2000) begin
      wait_clk(1);
      t++;
    end
    check(name, 32'(rx_exp.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    wait_clk(4);
    check("rst_miso",     32'(miso),     32'd1);
    check("rst_miso_oe",  32'(miso_oe),  32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd1);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata",  32'(m_tdata),  32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    wait_clk(8);

    // T1: mode 0, TX A5, master sends 3C
    set_mode(1'b0, 1'b0);
    tx_push(8'hA5);
    miso_exp.push_back(8'hA5);
    rx_exp.push_back(8'h3C);
    frame_q = {8'h3C};
    spi_frame(1'b1);
    drain("t1_rx_drain");

    // T2: modes 1..3, four-byte frame, TX bytes fed one at a time
    for (int m = 1; m < 4; m++) begin
      set_mode(1'(m >> 1), 1'(m & 1));
      n_under = 0;
      frame_q = {8'h96, 8'h0F, 8'hF0, 8'h69};
      foreach (frame_q[k]) rx_exp.push_back(frame_q[k]);
      for (int k = 1; k <= 4; k++) miso_exp.push_back(8'(k));
      tx_push(8'h01);
      fork
        spi_frame(1'b1);
        begin
          tx_push(8'h02);
          tx_push(8'h03);
          tx_push(8'h04);
          // CPHA=0 reloads on the last trailing edge; a pad byte keeps the holder non-empty there
          if (!cpha) tx_push(8'h00);
        end
      join
      check("t2_underrun_count", 32'(n_under), 32'd0);
      drain("t2_rx_drain");
    end

    // T3: mode 1, empty TX, two bytes -> fill bytes and two underrun pulses
    set_mode(1'b0, 1'b1);
    n_under = 0;
    frame_q = {8'h81, 8'h7E};
    rx_exp.push_back(8'h81);
    rx_exp.push_back(8'h7E);
    miso_exp.push_back(8'hFF);
    miso_exp.push_back(8'hFF);
    spi_frame(1'b1);
    check("t3_underrun_count", 32'(n_under), 32'd2);
    drain("t3_rx_drain");

    // T4: RX stalled over three bytes -> first byte held, two overruns
    set_mode(1'b0, 1'b0);
    m_tready = 1'b0;
    n_over = 0;
    rx_exp.push_back(8'h11);
    frame_q = {8'h11, 8'h22, 8'h33};
    spi_frame(1'b0);
    check("t4_overrun_count", 32'(n_over),   32'd2);
    check("t4_held_valid",    32'(m_tvalid), 32'd1);
    check("t4_held_data",     32'(m_tdata),  32'h11);
    m_tready = 1'b1;
    drain("t4_rx_drain");
    wait_clk(50);
    check("t4_no_more_beats", 32'(m_tvalid), 32'd0);

    // T5: CS aborts after 5 bits, then a full frame
    cs = 1'b0;
    wait_clk(HALF);
    spi_bits(8'hE7, 5, rd);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(4 * HALF);
    check("t5_no_partial_beat", 32'(m_tvalid), 32'd0);
    rx_exp.push_back(8'h5A);
    miso_exp.push_back(8'hFF);
    frame_q = {8'h5A};
    spi_frame(1'b1);
    drain("t5_rx_drain");

    // T6: reset mid-byte with CS low; held TX byte lost, nothing received until CS rises
    tx_push(8'h12);
    cs = 1'b0;
    wait_clk(HALF);
    tx_push(8'h34);
    spi_bits(8'hB4, 4, rd);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    check("t6_tready_after_rst", 32'(s_tready), 32'd1);
    check("t6_oe_after_rst",     32'(miso_oe),  32'd0);
    spi_bits(8'hAB, 8, rd);
    spi_bits(8'hCD, 4, rd);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(4 * HALF);
    check("t6_nothing_received", 32'(m_tvalid), 32'd0);
    rx_exp.push_back(8'hC3);
    miso_exp.push_back(8'hFF);
    frame_q = {8'hC3};
    spi_frame(1'b1);
    drain("t6_rx_drain");

    wait_clk(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
